mem_access_unit: RTL

Parametrised data-side memory access unit. Successor to the combinational RAM/IO dispatcher. It accepts one load or store through a valid/ready request port and decodes it into a RAM window or a memory-mapped IO register window. RAM is driven over an external req/ack port with variable latency; the IO registers are held internally. It returns aligned, sign- or zero-extended load data and an exception code over a valid/ready response port. It sits between the core's MEM stage and the data RAM / IO pins.

---
 rtl/mem_access_unit_pkg.sv | 13 +
 rtl/mem_lane_align.sv | 27 ++
 rtl/mem_access_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared width codes, exception codes and FSM encodings for the memory access unit.
package mem_access_unit_pkg;
  localparam logic [1:0] MEM_WIDTH_BYTE = 2'b00;
  localparam logic [1:0] MEM_WIDTH_HALF = 2'b01;
  localparam logic [1:0] MEM_WIDTH_WORD = 2'b10;
  localparam int EXCEPTION_LEN = 2;
  localparam logic [EXCEPTION_LEN-1:0] EXCEP_OK                = 2'd0;
  localparam logic [EXCEPTION_LEN-1:0] EXCEP_INVALID_MEM_READ  = 2'd1;
  localparam logic [EXCEPTION_LEN-1:0] EXCEP_INVALID_MEM_WRITE = 2'd2;
  localparam logic [1:0] MEMACC_IDLE     = 2'd0;
  localparam logic [1:0] MEMACC_RAM_WAIT = 2'd1;
  localparam logic [1:0] MEMACC_RESP     = 2'd2;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte enables, write lane shift, read shift/extension and alignment check.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_width,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic        o_aligned,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);
  logic [31:0] w_rsh;
  always_comb begin
    o_aligned = (i_width == MEM_WIDTH_BYTE) ||
                (i_width == MEM_WIDTH_HALF && !i_addr_lo[0]) ||
                (i_width == MEM_WIDTH_WORD && i_addr_lo == 2'b00);
    o_be      = i_width == MEM_WIDTH_WORD ? 4'hF :
                i_width == MEM_WIDTH_HALF ? (i_addr_lo[1] ? 4'hC : 4'h3) : 4'b0001 << i_addr_lo;
    o_wdata   = i_wdata << {i_addr_lo, 3'b000};
    w_rsh     = i_rdata >> {i_addr_lo, 3'b000};
    o_rdata   = i_width == MEM_WIDTH_BYTE ? {{24{i_signed & w_rsh[7]}}, w_rsh[7:0]} :
                i_width == MEM_WIDTH_HALF ? {{16{i_signed & w_rsh[15]}}, w_rsh[15:0]} : w_rsh;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: valid/ready load/store unit decoding into a RAM req/ack port or internal IO registers.
// Optional RAM ack watchdog enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter logic [31:0] RAM_BASE       = 32'h40000000,
  parameter int          RAM_SIZE_LOG2  = 29,
  parameter logic [31:0] IO_BASE        = 32'h60000000,
  parameter int          IO_WORDS       = 1,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid_In,
  output logic                       req_ready_Out,
  input  logic [31:0]                addr_In,
  input  logic [31:0]                data_In,
  input  logic [1:0]                 dataWidth_In,
  input  logic                       isRead_In,
  input  logic                       isSigned_In,
  output logic                       resp_valid_Out,
  input  logic                       resp_ready_In,
  output logic [31:0]                data_Out,
  output logic [EXCEPTION_LEN-1:0]   exception_Out,
  output logic                       ram_req_Out,
  output logic                       ram_we_Out,
  output logic [RAM_SIZE_LOG2-3:0]   ram_addr_Out,
  output logic [31:0]                ram_wdata_Out,
  output logic [3:0]                 ram_be_Out,
  input  logic [31:0]                ram_rdata_In,
  input  logic                       ram_ack_In,
  output logic [32*IO_WORDS-1:0]     io_state_Out
);
  localparam logic [32:0] RAM_END = {1'b0, RAM_BASE} + (33'd1 << RAM_SIZE_LOG2);
  localparam logic [32:0] IO_END  = {1'b0, IO_BASE} + 33'(4 * IO_WORDS);
  logic [1:0]               r_state;
  logic                     r_rd, r_signed, r_ram_req, r_we;
  logic [1:0]               r_width, r_addr_lo;
  logic [3:0]               r_be;
  logic [31:0]              r_wdata, r_data;
  logic [RAM_SIZE_LOG2-3:0] r_ram_addr;
  logic [EXCEPTION_LEN-1:0] r_exc;
  logic [32*IO_WORDS-1:0]   r_io;
  logic [32:0]              w_addr33;
  logic                     w_idle, w_accept, w_ram_hit, w_io_hit, w_aligned, w_fault, w_tmo;
  logic [29:0]              w_io_idx;
  logic [31:0]              w_io_rd, w_wsh, w_rext;
  logic [3:0]               w_be;
  logic [EXCEPTION_LEN-1:0] w_fexc;
  always_comb begin
    w_addr33  = {1'b0, addr_In};
    w_idle    = r_state == MEMACC_IDLE;
    w_accept  = w_idle && req_valid_In;
    w_ram_hit = w_addr33 >= {1'b0, RAM_BASE} && w_addr33 < RAM_END;
    w_io_hit  = !w_ram_hit && w_addr33 >= {1'b0, IO_BASE} && w_addr33 < IO_END;
    w_io_idx  = 30'((addr_In - IO_BASE) >> 2);
    w_io_rd   = '0;
    for (int k = 0; k < IO_WORDS; k++)
      if (w_io_idx == 30'(k)) w_io_rd = r_io[32*k+:32];
    w_fault   = !(w_aligned && (w_ram_hit || w_io_hit));
    w_fexc    = isRead_In ? EXCEP_INVALID_MEM_READ : EXCEP_INVALID_MEM_WRITE;
  end
  // One aligner serves both paths: live request fields in IDLE, latched fields while awaiting RAM.
  mem_lane_align u_align (
    .i_addr_lo (w_idle ? addr_In[1:0] : r_addr_lo),
    .i_width   (w_idle ? dataWidth_In : r_width),
    .i_signed  (w_idle ? isSigned_In : r_signed),
    .i_wdata   (data_In),
    .i_rdata   (w_idle ? w_io_rd : ram_rdata_In),
    .o_aligned (w_aligned),
    .o_be      (w_be),
    .o_wdata   (w_wsh),
    .o_rdata   (w_rext)
  );
`ifdef MEM_ACCESS_TIMEOUT_EN
  logic [31:0] r_tmo;
  assign w_tmo = r_tmo == 32'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_tmo <= '0;
    else r_tmo <= (r_state == MEMACC_RAM_WAIT && !ram_ack_In) ? r_tmo + 32'd1 : '0;
  end
`else
  assign w_tmo = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= MEMACC_IDLE;
      r_rd       <= 1'b0;
      r_signed   <= 1'b0;
      r_width    <= '0;
      r_addr_lo  <= '0;
      r_ram_req  <= 1'b0;
      r_we       <= 1'b0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_ram_addr <= '0;
      r_data     <= '0;
      r_exc      <= EXCEP_OK;
    end else if (w_accept) begin
      r_rd      <= isRead_In;
      r_signed  <= isSigned_In;
      r_width   <= dataWidth_In;
      r_addr_lo <= addr_In[1:0];
      r_exc     <= w_fault ? w_fexc : EXCEP_OK;
      r_data    <= (!w_fault && w_io_hit && isRead_In) ? w_rext : '0;
      r_state   <= (!w_fault && w_ram_hit) ? MEMACC_RAM_WAIT : MEMACC_RESP;
      if (!w_fault && w_ram_hit) begin
        r_ram_req  <= 1'b1;
        r_we       <= !isRead_In;
        r_be       <= w_be;
        r_wdata    <= w_wsh;
        r_ram_addr <= addr_In[RAM_SIZE_LOG2-1:2];
      end
    end else if (r_state == MEMACC_RAM_WAIT && (ram_ack_In || w_tmo)) begin
      r_ram_req <= 1'b0;
      r_state   <= MEMACC_RESP;
      r_data    <= (ram_ack_In && r_rd) ? w_rext : '0;
      r_exc     <= ram_ack_In ? EXCEP_OK : (r_rd ? EXCEP_INVALID_MEM_READ : EXCEP_INVALID_MEM_WRITE);
    end else if (r_state == MEMACC_RESP && resp_ready_In) begin
      r_state <= MEMACC_IDLE;
      r_data  <= '0;
      r_exc   <= EXCEP_OK;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_io <= '0;
    else if (w_accept && !w_fault && w_io_hit && !isRead_In)
      for (int k = 0; k < IO_WORDS; k++)
        for (int b = 0; b < 4; b++)
          if (w_io_idx == 30'(k) && w_be[b]) r_io[32*k+8*b+:8] <= w_wsh[8*b+:8];
  end
  assign req_ready_Out  = w_idle;
  assign resp_valid_Out = r_state == MEMACC_RESP;
  assign data_Out       = r_data;
  assign exception_Out  = r_exc;
  assign ram_req_Out    = r_ram_req;
  assign ram_we_Out     = r_we;
  assign ram_addr_Out   = r_ram_addr;
  assign ram_wdata_Out  = r_wdata;
  assign ram_be_Out     = r_be;
  assign io_state_Out   = r_io;
endmodule
